uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter among several requesters, each sending one 32-bit word as a fixed sequence of bytes. It sits between the MIPS32-side producers (CPU store path, debug/trace units) and the UART's `din`/`enable`/`tx_busy` ports. It serialises whole words into byte writes, sequences each write against `tx_busy`, and returns a one-cycle completion pulse to the owner.

## Interface

**Parameters**
- `NREQ`, default 4: number of requesters, 2..8.
- `BYTES`, default 4: bytes per word, 1..4. Little-endian: byte 0 is `data[7:0]`.
- `HI_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after a write before treating the byte as sent.

**Ports**
- `Clock` in 1: single clock for the whole block.
- `Reset` in 1: reset. Synchronous, active-low.
- `req` in NREQ: per-requester request level.
- `data` in NREQ*32: word for requester i at `[32*i+31:32*i]`.
- `ack` out NREQ: one-cycle pulse when requester i's word has fully left the transmitter.
- `owner` out 3: index of the current or last granted requester.
- `busy` out 1: high from grant through the ack cycle.
- `tx_din` out 8: byte to the UART `din`.
- `tx_wr_en` out 1: write strobe to the UART `enable`.
- `tx_busy` in 1: UART transmitter busy.

## Operation

**FSM states:** IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.

- **IDLE:** if any `req` is high, grant the first requester searching upward from `last+1` with wrap, where `last` resets to NREQ-1 so requester 0 wins first. On grant, latch `data` into a 32-bit shift register, set `byte_cnt`=0, `owner`=grant index, then go to ISSUE.
- **ISSUE:** `tx_din` = shift register `[7:0]`, registered and held stable. While `tx_busy`=1, stay. When `tx_busy`=0, `tx_wr_en`=1 for that cycle, clear `to_cnt`, go to WAIT_HI.
- **WAIT_HI:** go to WAIT_LO when `tx_busy`=1 or `to_cnt`=HI_TIMEOUT-1. Otherwise increment `to_cnt`.
- **WAIT_LO:** when `tx_busy`=0:
  - if `byte_cnt`=BYTES-1, go to DONE;
  - else shift right by 8, `byte_cnt`++, go to ISSUE.
- **DONE:** `ack[owner]`=1 for one cycle, `last`=`owner`, go to IDLE.

**Rules**
- `tx_wr_en` = (state==ISSUE) && !`tx_busy`. It is combinational from registered state, never high two consecutive cycles, and never high while `tx_busy`=1.
- `data` is sampled only at grant. Later changes are ignored until the next grant.
- A requester dropping `req` mid-word does not abort. The word completes and `ack` still pulses.
- A requester holding `req` through its `ack` is re-eligible only after all other pending requesters have been served once.
- `req` bits at index ≥ NREQ do not exist. A grant index is always < NREQ.
- Widths: `byte_cnt` is 2 bits and `to_cnt` is clog2(HI_TIMEOUT) bits. `to_cnt` saturates and never wraps.
- **Reset mid-transfer:** next edge forces IDLE, and `tx_wr_en`, `ack`, `busy` go low immediately after that edge. A byte already handed to the UART finishes on the line, but no ack is produced.

**Reset values:** state IDLE, `ack`=0, `busy`=0, `tx_din`=8'h00, `tx_wr_en`=0, `owner`=0, `last`=NREQ-1, counters 0.

## Timing

- Grant latency: `req` sampled high in IDLE at edge N, so ISSUE is entered and `busy`=1 after edge N.
- If `tx_busy`=0, `tx_wr_en` is high in cycle N+1.
- Per byte:
  - 1 ISSUE cycle, plus any wait for `tx_busy` to fall;
  - 1..HI_TIMEOUT cycles in WAIT_HI;
  - the UART frame time in WAIT_LO.
- `ack` is high in the cycle after WAIT_LO sees `tx_busy`=0 on the last byte. `busy` falls together with `ack`.
- IDLE re-arbitrates on the cycle after DONE. Minimum gap between grants is 1 idle cycle.
- `tx_busy` is treated as synchronous to `Clock`.

## Structure

- Shared include `uart_ctrl_defs.vh`: FSM state encodings (3-bit localparams), default `NREQ`/`BYTES`/`HI_TIMEOUT`, byte-order constant.
- Sub-module `rr_arbiter`:
  - parameter NREQ; inputs `req`, `last`; output one-hot `gnt` and `gnt_idx`;
  - purely combinational rotate-priority-encode, instantiated once.
- The FSM, shift register and counters live in `uart_tx_scheduler`.

## Test plan

- **Single word:** reset low 3 cycles, then high. `req[0]`=1 with `data[31:0]`=32'hDEADBEEF, UART model raising `tx_busy` 1 cycle after `enable` for 10 cycles.
  - Expect `tx_din` sequence EF, BE, AD, DE, exactly 4 `tx_wr_en` pulses, one `ack[0]` pulse, `busy` low after.
- **Round-robin:** `req`=4'b1111 held, words 0x11111111..0x44444444.
  - Expect grants 0,1,2,3,0 and `ack` order 0,1,2,3.
  - Drop `req[2]` before its grant: expect 0,1,3,0,1.
- **Back-pressure:** `tx_busy` held high 50 cycles at grant.
  - Expect no `tx_wr_en` until `tx_busy` falls, then a single pulse on the first low cycle.
- **Timeout:** UART model never raises `tx_busy`, HI_TIMEOUT=16.
  - Expect each byte to advance after 16 WAIT_HI cycles, 4 writes total, `ack` still pulses.
- **Data/req changes after grant:** change `data[0]` to 0 and drop `req[0]` one cycle after grant.
  - Expect the original 4 bytes sent and `ack[0]` pulsed.
- **Reset mid-word:** assert `Reset`=0 during byte 2's WAIT_LO.
  - Expect IDLE after the edge, `ack`/`busy`/`tx_wr_en` low, no further writes.
  - After release with `req[1]`=1, requester 1 is served. Its word is sent in full: 4 bytes, 4 `tx_wr_en` pulses, one `ack[1]`.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: FSM state encoding and default parameters for the UART transmit scheduler
package uart_tx_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_BYTES = 4;
  localparam int DEF_HI_TIMEOUT = 16;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester handshake plus UART din/enable/tx_busy signals
interface uart_tx_scheduler_if import uart_tx_scheduler_pkg::*; #(parameter int NREQ = DEF_NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*32-1:0] data;
  logic [NREQ-1:0] ack;
  logic [2:0] owner;
  logic busy;
  logic [7:0] tx_din;
  logic tx_wr_en;
  logic tx_busy;
  modport master (input req, data, tx_busy, output ack, owner, busy, tx_din, tx_wr_en);
  modport slave (output req, data, tx_busy, input ack, owner, busy, tx_din, tx_wr_en);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder, first request above last wins
module rr_arbiter import uart_tx_scheduler_pkg::*; #(parameter int NREQ = DEF_NREQ) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx
);
  logic [NREQ-1:0] rot;
  int off;
  always_comb begin
    rot = NREQ'({req, req} >> (int'(last) + 1));
    off = 0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? i : off;
    gnt_idx = 3'((int'(last) + 1 + off) % NREQ);
    gnt = |req ? NREQ'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter, one 32-bit word per grant
module uart_tx_scheduler import uart_tx_scheduler_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int BYTES = DEF_BYTES,
  parameter int HI_TIMEOUT = DEF_HI_TIMEOUT
) (
  input logic Clock,
  input logic Reset,
  uart_tx_scheduler_if.master bus
);
  localparam int TW = HI_TIMEOUT > 1 ? $clog2(HI_TIMEOUT) : 1;
  state_t state, state_n;
  logic [31:0] sh, word;
  logic [1:0] byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0] last, owner, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic hi_done, last_byte;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req), .last(last), .gnt(gnt), .gnt_idx(gnt_idx));
  assign word = 32'(bus.data >> (32 * gnt_idx));
  assign hi_done = bus.tx_busy || to_cnt == TW'(HI_TIMEOUT - 1);
  assign last_byte = byte_cnt == 2'(BYTES - 1);
  assign bus.tx_din = sh[7:0];
  assign bus.tx_wr_en = state == ISSUE && !bus.tx_busy;
  assign bus.busy = state != IDLE;
  assign bus.ack = state == DONE ? NREQ'(1) << owner : '0;
  assign bus.owner = owner;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |gnt ? ISSUE : IDLE;
      ISSUE:   state_n = bus.tx_busy ? ISSUE : WAIT_HI;
      WAIT_HI: state_n = hi_done ? WAIT_LO : WAIT_HI;
      WAIT_LO: state_n = bus.tx_busy ? WAIT_LO : (last_byte ? DONE : ISSUE);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      sh <= '0;
      byte_cnt <= '0;
      to_cnt <= '0;
      last <= 3'(NREQ - 1);
      owner <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |gnt) begin
        sh <= word;
        byte_cnt <= '0;
        owner <= gnt_idx;
      end
      if (state == ISSUE) to_cnt <= '0;
      if (state == WAIT_HI && !hi_done) to_cnt <= to_cnt + TW'(1);
      if (state == WAIT_LO && !bus.tx_busy && !last_byte) begin
        sh <= sh >> 8;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == DONE) last <= owner;
    end
  end
endmodule
